// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared defaults, display-mode encoding and duty type for the LED PWM driver
package led_pwm_pkg;
  localparam int NUM_LED_DEF = 8;
  localparam int DUTY_W_DEF = 8;
  typedef enum logic {MODE_PWM = 1'b0, MODE_HEARTBEAT = 1'b1} mode_e;
  typedef logic [DUTY_W_DEF-1:0] duty_t;
endpackage

// File: rtl/led_pwm_driver_if.sv
// led_pwm_driver_if: valid/ready duty write port from the HPS PIO side
interface led_pwm_driver_if
  import led_pwm_pkg::*;
#(
  parameter int NUM_LED = NUM_LED_DEF,
  parameter int DUTY_W = DUTY_W_DEF
);
  localparam int IDX_W = NUM_LED > 1 ? $clog2(NUM_LED) : 1;
  logic wr_valid;
  logic wr_ready;
  logic [IDX_W-1:0] wr_index;
  logic [DUTY_W-1:0] wr_duty;
  modport master(output wr_valid, wr_index, wr_duty, input wr_ready);
  modport slave(input wr_valid, wr_index, wr_duty, output wr_ready);
endinterface

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler and PWM phase counter with tick and period-end commit strobes
module pwm_timebase #(
  parameter int DUTY_W = 8,
  parameter int PRESCALE = 195
) (
  input  logic clk,
  input  logic rst_n,
  output logic [DUTY_W-1:0] phase,
  output logic tick,
  output logic commit
);
  localparam int PS_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PS_W-1:0] pre;
  assign tick = pre == PS_W'(PRESCALE - 1);
  assign commit = tick && &phase;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
      phase <= '0;
    end else begin
      pre <= tick ? '0 : pre + PS_W'(1);
      phase <= tick ? phase + DUTY_W'(1) : phase;
    end
  end
endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: per-LED PWM brightness with period-aligned duty commit and heartbeat display
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter int NUM_LED = NUM_LED_DEF,
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int PRESCALE = 195
) (
  input  logic FPGA_CLK1_50,
  input  logic hps_fpga_reset_n,
  led_pwm_driver_if.slave wr,
  input  logic mode,
  output logic [NUM_LED-1:0] LED
);
  localparam int IDX_W = NUM_LED > 1 ? $clog2(NUM_LED) : 1;
  logic [DUTY_W-1:0] phase;
  logic tick;
  logic commit;
  logic wr_en;
  logic [31:0] hb_cnt;
  logic [NUM_LED-1:0] hb;
  logic [NUM_LED-1:0] pwm;
  pwm_timebase #(.DUTY_W(DUTY_W), .PRESCALE(PRESCALE)) u_timebase (
    .clk(FPGA_CLK1_50),
    .rst_n(hps_fpga_reset_n),
    .phase(phase),
    .tick(tick),
    .commit(commit)
  );
  // writes are refused on the commit edge so shadow never changes while it is being copied
  assign wr.wr_ready = hps_fpga_reset_n && !(tick && commit);
  assign wr_en = wr.wr_valid && wr.wr_ready;
  assign hb = hb_cnt[31 -: NUM_LED];
  for (genvar i = 0; i < NUM_LED; i++) begin : g_led
    logic [DUTY_W-1:0] shadow;
    logic [DUTY_W-1:0] active;
    always_ff @(posedge FPGA_CLK1_50) begin
      if (!hps_fpga_reset_n) begin
        shadow <= '0;
        active <= '0;
      end else begin
        if (wr_en && wr.wr_index == IDX_W'(i)) shadow <= wr.wr_duty;
        if (commit) active <= shadow;
      end
    end
    assign pwm[i] = &active || phase < active;
  end
  always_ff @(posedge FPGA_CLK1_50) begin
    if (!hps_fpga_reset_n) begin
      hb_cnt <= '0;
      LED <= '0;
    end else begin
      hb_cnt <= hb_cnt + 32'd1;
      LED <= mode == MODE_HEARTBEAT ? hb : pwm;
    end
  end
endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: directed self-checking bench for led_pwm_driver at PRESCALE=2
module tb_led_pwm_driver;
  logic clk = 0;
  logic rst_n = 0;
  logic mode = 0;
  logic mode6 = 0;
  logic [7:0] led;
  logic [5:0] led6;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  led_pwm_driver_if #(.NUM_LED(8), .DUTY_W(8)) bus ();
  led_pwm_driver_if #(.NUM_LED(6), .DUTY_W(8)) bus6 ();
  led_pwm_driver #(.NUM_LED(8), .DUTY_W(8), .PRESCALE(2)) dut (
    .FPGA_CLK1_50(clk), .hps_fpga_reset_n(rst_n), .wr(bus), .mode(mode), .LED(led));
  led_pwm_driver #(.NUM_LED(6), .DUTY_W(8), .PRESCALE(2)) dut6 (
    .FPGA_CLK1_50(clk), .hps_fpga_reset_n(rst_n), .wr(bus6), .mode(mode6), .LED(led6));
  always #5 clk = ~clk;
  // non-reset edges since release; a commit edge leaves cyc % 512 == 0
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_commit;
    do step(); while (cyc % 512 != 0);
  endtask
  task automatic wr(input bit sel, input int idx, input int duty);
    logic rdy;
    @(negedge clk);
    if (sel) begin
      bus6.wr_valid = 1; bus6.wr_index = 3'(idx); bus6.wr_duty = 8'(duty);
    end else begin
      bus.wr_valid = 1; bus.wr_index = 3'(idx); bus.wr_duty = 8'(duty);
    end
    rdy = sel ? bus6.wr_ready : bus.wr_ready;
    for (int k = 0; k < 4 && !rdy; k++) begin
      @(negedge clk);
      rdy = sel ? bus6.wr_ready : bus.wr_ready;
    end
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL wr_accept idx=%0d got_ready=%b exp=1", idx, rdy);
    end
    @(negedge clk);
    bus.wr_valid = 0;
    bus6.wr_valid = 0;
  endtask
  function automatic logic [7:0] exp_pwm(input int n);
    int p = ((n - 1) >> 1) & 255;
    return {1'b0, 1'b0, p < 'h90, p < 'h10, 1'b0, 1'b1, 1'b0, p < 'h40};
  endfunction
  task automatic test_reset;
    int hi = 0;
    repeat (3) step();
    checks++;
    if (led !== 8'h00 || bus.wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial led=%0h ready=%b exp led=0 ready=0", led, bus.wr_ready);
    end
    @(negedge clk) rst_n = 1;
    wr(0, 3, 'h80);
    repeat (100) step();
    @(negedge clk) rst_n = 0;
    repeat (5) begin
      step();
      checks++;
      if (led !== 8'h00) begin
        failures++;
        $display("FAIL reset_led got=%0h exp=0", led);
      end
      checks++;
      if (bus.wr_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_ready got=%b exp=0", bus.wr_ready);
      end
    end
    @(negedge clk) rst_n = 1;
    step();
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_release got=%b exp=1", bus.wr_ready);
    end
    wait_commit();
    repeat (512) begin
      step();
      hi += int'(led[3]);
    end
    checks++;
    if (hi != 0) begin
      failures++;
      $display("FAIL reset_discard led3_high_cycles got=%0d exp=0", hi);
    end
  endtask
  task automatic test_basic_duty;
    int hi = 0;
    wr(0, 0, 'h40);
    wait_commit();
    checks++;
    if (led[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_commit_cycle led0 got=%b exp=0", led[0]);
    end
    for (int j = 1; j <= 512; j++) begin
      step();
      hi += int'(led[0]);
      if (j == 1 || j == 129) begin
        checks++;
        if (led[0] !== (j == 1)) begin
          failures++;
          $display("FAIL basic_edge j=%0d led0 got=%b exp=%b", j, led[0], j == 1);
        end
      end
    end
    checks++;
    if (hi != 128) begin
      failures++;
      $display("FAIL basic_high_cycles got=%0d exp=128", hi);
    end
  endtask
  task automatic test_extremes;
    int hi1 = 0;
    int lo2 = 0;
    wr(0, 1, 'h00);
    wr(0, 2, 'hFF);
    wait_commit();
    repeat (1536) begin
      step();
      hi1 += int'(led[1]);
      lo2 += int'(!led[2]);
    end
    checks++;
    if (hi1 != 0) begin
      failures++;
      $display("FAIL duty0_high_cycles got=%0d exp=0", hi1);
    end
    checks++;
    if (lo2 != 0) begin
      failures++;
      $display("FAIL dutymax_low_cycles got=%0d exp=0", lo2);
    end
  endtask
  task automatic test_back_to_back;
    int lows = 0;
    int badpos = 0;
    int bad4 = 0;
    bit seen = 0;
    @(negedge clk);
    bus.wr_valid = 1; bus.wr_index = 3'd4; bus.wr_duty = 8'h10;
    repeat (1100) begin
      step();
      if (!bus.wr_ready) lows++;
      if (bus.wr_ready !== (cyc % 512 != 511)) badpos++;
      if (led[4] !== (seen && (((cyc - 1) >> 1) & 255) < 16)) bad4++;
      if (cyc % 512 == 0) seen = 1;
    end
    @(negedge clk) bus.wr_valid = 0;
    checks++;
    if (lows != 2) begin
      failures++;
      $display("FAIL bp_ready_low_cycles got=%0d exp=2", lows);
    end
    checks++;
    if (badpos != 0) begin
      failures++;
      $display("FAIL bp_ready_position mismatches got=%0d exp=0", badpos);
    end
    checks++;
    if (bad4 != 0) begin
      failures++;
      $display("FAIL bp_led4_pattern mismatches got=%0d exp=0", bad4);
    end
  endtask
  task automatic test_multi_write;
    int hi = 0;
    int bad6 = 0;
    wait_commit();
    wr(0, 5, 'h20);
    wr(0, 5, 'h30);
    wr(0, 5, 'h90);
    wr(0, 7, 'h00);
    wr(1, 5, 'hFF);
    wr(1, 6, 'hFF);
    wr(1, 7, 'hFF);
    wait_commit();
    repeat (512) begin
      step();
      hi += int'(led[5]);
      if (led6 !== 6'b100000) bad6++;
    end
    checks++;
    if (hi != 288) begin
      failures++;
      $display("FAIL last_write_wins led5_high_cycles got=%0d exp=288", hi);
    end
    checks++;
    if (bad6 != 0) begin
      failures++;
      $display("FAIL out_of_range_ignored led6 mismatches got=%0d exp=0", bad6);
    end
  endtask
  task automatic test_heartbeat;
    logic [7:0] hb_exp [3] = '{8'hFF, 8'hFF, 8'h00};
    @(negedge clk);
    mode = 1;
    force dut.hb_cnt = 32'hFFFF_FFFE;
    #1 release dut.hb_cnt;
    for (int j = 0; j < 3; j++) begin
      step();
      checks++;
      if (led !== hb_exp[j]) begin
        failures++;
        $display("FAIL heartbeat_wrap step=%0d got=%0h exp=%0h", j, led, hb_exp[j]);
      end
    end
    @(negedge clk) mode = 0;
    repeat (4) begin
      step();
      checks++;
      if (led !== exp_pwm(cyc)) begin
        failures++;
        $display("FAIL pwm_restore cyc=%0d got=%0h exp=%0h", cyc, led, exp_pwm(cyc));
      end
    end
  endtask
  initial begin
    bus.wr_valid = 0; bus.wr_index = '0; bus.wr_duty = '0;
    bus6.wr_valid = 0; bus6.wr_index = '0; bus6.wr_duty = '0;
    test_reset();
    test_basic_duty();
    test_extremes();
    test_back_to_back();
    test_multi_write();
    test_heartbeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
